// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : div_pkg
//  Description : Shared types and default widths for the sequential
//                restoring divider.
//                - state_t   : divider FSM state encoding
//                - DW_DEF    : default dividend/quotient width
//                - VW_DEF    : default divisor/remainder width
//                - CNT_W     : bit-counter width for the default dividend width
//  Revision    : 1.0  initial release
// ============================================================================
package div_pkg;

    localparam int DW_DEF = 8;
    localparam int VW_DEF = 4;
    localparam int CNT_W  = $clog2(DW_DEF);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : div_pkg
`default_nettype wire

// File: rtl/div_restore_step.sv
`default_nettype none
// ============================================================================
//  Module      : div_restore_step
//  Description : One combinational restoring-division step.
//                The partial remainder is shifted left and the next dividend
//                bit is brought in to form the trial value. If the trial is at
//                least the divisor, the divisor is subtracted and the quotient
//                bit is 1. Otherwise the trial is kept and the quotient bit is 0.
//  Ports       : i_rem     [VW:0]   current partial remainder
//                i_bit              incoming dividend bit (MSB first)
//                i_divisor [VW-1:0] divisor
//                o_rem     [VW:0]   next partial remainder
//                o_qbit             quotient bit produced by this step
//  Revision    : 1.0  initial release
// ============================================================================
module div_restore_step #(
    parameter int VW = 4
) (
    input  logic [VW:0]   i_rem,
    input  logic          i_bit,
    input  logic [VW-1:0] i_divisor,
    output logic [VW:0]   o_rem,
    output logic          o_qbit
);

    logic [VW:0] w_trial;
    logic [VW:0] w_diff;
    logic        w_ge;

    // The incoming remainder is always below the divisor, so its top bit is
    // zero in normal use. Should it be set, the true trial value would exceed
    // 2^(VW+1), which is always >= divisor. Folding that bit into the compare
    // keeps the step arithmetically exact for any input. The modulo
    // subtraction below still yields the correct (small) difference.
    assign w_trial = {i_rem[VW-1:0], i_bit};
    assign w_ge    = i_rem[VW] | (w_trial >= {1'b0, i_divisor});
    assign w_diff  = w_trial - {1'b0, i_divisor};

    assign o_rem  = w_ge ? w_diff : w_trial;
    assign o_qbit = w_ge;

endmodule : div_restore_step
`default_nettype wire

// File: rtl/seq_restoring_divider.sv
`default_nettype none
// ============================================================================
//  Module      : seq_restoring_divider
//  Description : Multi-cycle unsigned restoring divider. It produces one
//                quotient bit per clock behind a start/busy/done handshake.
//                A non-zero divisor completes DW+1 cycles after start.
//                A zero divisor completes in 1 cycle and returns an all-ones
//                quotient with the div_by_zero flag set.
//  Ports       : clk                    rising-edge clock
//                rst                    synchronous active-high reset
//                start                  request a division (sampled in IDLE)
//                dividend    [DW-1:0]   unsigned dividend
//                divisor     [VW-1:0]   unsigned divisor
//                busy                   high in CALC and DONE
//                done                   one-cycle completion pulse
//                quotient    [DW-1:0]   registered quotient
//                remainder   [VW-1:0]   registered remainder
//                div_by_zero            registered divide-by-zero flag
//  Revision    : 1.0  initial release
// ============================================================================
module seq_restoring_divider
    import div_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int VW = VW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_by_zero
);

    // The counter is sized from this instance's DW, not the package default,
    // so that overriding DW keeps the counter wide enough.
    localparam int            C_CW       = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [C_CW-1:0] C_CNT_LAST = C_CW'(DW - 1);

    state_t          r_state_q,     w_state_d;
    logic [C_CW-1:0] r_cnt_q,       w_cnt_d;
    logic [DW-1:0]   r_dvd_q,       w_dvd_d;        // dividend shift register
    logic [VW-1:0]   r_dvs_q,       w_dvs_d;        // latched divisor
    logic [VW:0]     r_rem_q,       w_rem_d;        // partial remainder
    logic [DW-1:0]   r_quo_q,       w_quo_d;        // quotient shift register
    logic [DW-1:0]   r_quotient_q,  w_quotient_d;
    logic [VW-1:0]   r_remainder_q, w_remainder_d;
    logic            r_dbz_q,       w_dbz_d;

    logic [VW:0]     w_step_rem;
    logic            w_step_qbit;

    div_restore_step #(
        .VW (VW)
    ) u_step (
        .i_rem     (r_rem_q),
        .i_bit     (r_dvd_q[DW-1]),
        .i_divisor (r_dvs_q),
        .o_rem     (w_step_rem),
        .o_qbit    (w_step_qbit)
    );

    always_comb begin
        w_state_d     = r_state_q;
        w_cnt_d       = r_cnt_q;
        w_dvd_d       = r_dvd_q;
        w_dvs_d       = r_dvs_q;
        w_rem_d       = r_rem_q;
        w_quo_d       = r_quo_q;
        w_quotient_d  = r_quotient_q;
        w_remainder_d = r_remainder_q;
        w_dbz_d       = r_dbz_q;

        case (r_state_q)
            ST_IDLE: begin
                if (start) begin
                    if (divisor == '0) begin
                        w_quotient_d  = '1;
                        w_remainder_d = '0;
                        w_dbz_d       = 1'b1;
                        w_state_d     = ST_DONE;
                    end else begin
                        w_dvd_d   = dividend;
                        w_dvs_d   = divisor;
                        w_rem_d   = '0;
                        w_quo_d   = '0;
                        w_cnt_d   = C_CNT_LAST;
                        w_state_d = ST_CALC;
                    end
                end
            end

            ST_CALC: begin
                w_dvd_d = {r_dvd_q[DW-2:0], 1'b0};
                w_rem_d = w_step_rem;
                w_quo_d = {r_quo_q[DW-2:0], w_step_qbit};
                w_cnt_d = r_cnt_q - 1'b1;
                if (r_cnt_q == '0) begin
                    // Publish the results on the final step so they are
                    // already valid in the DONE cycle.
                    w_quotient_d  = {r_quo_q[DW-2:0], w_step_qbit};
                    w_remainder_d = w_step_rem[VW-1:0];
                    w_dbz_d       = 1'b0;
                    w_state_d     = ST_DONE;
                end
            end

            ST_DONE: begin
                w_state_d = ST_IDLE;
            end

            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q     <= ST_IDLE;
            r_cnt_q       <= '0;
            r_dvd_q       <= '0;
            r_dvs_q       <= '0;
            r_rem_q       <= '0;
            r_quo_q       <= '0;
            r_quotient_q  <= '0;
            r_remainder_q <= '0;
            r_dbz_q       <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_cnt_q       <= w_cnt_d;
            r_dvd_q       <= w_dvd_d;
            r_dvs_q       <= w_dvs_d;
            r_rem_q       <= w_rem_d;
            r_quo_q       <= w_quo_d;
            r_quotient_q  <= w_quotient_d;
            r_remainder_q <= w_remainder_d;
            r_dbz_q       <= w_dbz_d;
        end
    end

    assign busy        = (r_state_q != ST_IDLE);
    assign done        = (r_state_q == ST_DONE);
    assign quotient    = r_quotient_q;
    assign remainder   = r_remainder_q;
    assign div_by_zero = r_dbz_q;

endmodule : seq_restoring_divider
`default_nettype wire

// File: tb/tb_seq_restoring_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_restoring_divider
//  Description : Self-checking bench for seq_restoring_divider. Expected
//                results come from plain integer division and modulo.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seq_restoring_divider;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] dividend = '0;
    logic [3:0] divisor = '0;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Outputs the DUT is expected to be holding between completions.
    logic [7:0] exp_quo = '0;
    logic [3:0] exp_rem = '0;
    logic       exp_dbz = 1'b0;

    always #5 clk = ~clk;

    seq_restoring_divider #(
        .DW (8),
        .VW (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Run one division and check the handshake timing, the held outputs and the result.
    task automatic run_div(input logic [7:0] a, input logic [3:0] b);
        int         lat;
        int         exp_lat;
        logic [7:0] eq;
        logic [3:0] er;
        logic       ez;
        if (b == 0) begin
            eq = 8'hFF; er = 4'd0; ez = 1'b1; exp_lat = 1;
        end else begin
            eq = 8'(int'(a) / int'(b));
            er = 4'(int'(a) % int'(b));
            ez = 1'b0;
            exp_lat = 9;
        end
        @(negedge clk);
        start = 1'b1; dividend = a; divisor = b;
        @(negedge clk);
        start = 1'b0;
        dividend = 8'($urandom);
        divisor  = 4'($urandom);
        lat = 1;
        while (done !== 1'b1 && lat <= 20) begin
            chk("busy_calc", {31'd0, busy}, 32'd1);
            chk("hold_quotient", {24'd0, quotient}, {24'd0, exp_quo});
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, exp_lat);
        chk("busy_done", {31'd0, busy}, 32'd1);
        chk("quotient", {24'd0, quotient}, {24'd0, eq});
        chk("remainder", {28'd0, remainder}, {28'd0, er});
        chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, ez});
        exp_quo = eq; exp_rem = er; exp_dbz = ez;
        @(negedge clk);
        chk("done_pulse_end", {31'd0, done}, 32'd0);
        chk("busy_idle", {31'd0, busy}, 32'd0);
        chk("hold_after", {24'd0, quotient}, {24'd0, exp_quo});
    endtask

    initial begin
        int n;
        logic [7:0] ra;
        logic [3:0] rb;

        // Reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_quotient", {24'd0, quotient}, 32'd0);
        chk("rst_remainder", {28'd0, remainder}, 32'd0);
        chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);

        // Directed cases
        run_div(8'd35, 4'd5);
        run_div(8'd225, 4'd15);
        run_div(8'd255, 4'd1);
        run_div(8'd100, 4'd7);
        run_div(8'd6, 4'd10);
        run_div(8'd200, 4'd0);
        run_div(8'd72, 4'd9);

        // Starts while busy (CALC cycle 3 and DONE cycle) are ignored
        @(negedge clk);
        start = 1'b1; dividend = 8'd100; divisor = 4'd7;
        @(negedge clk);                       // CALC cycle 1
        start = 1'b0;
        @(negedge clk);                       // CALC cycle 2
        @(negedge clk);                       // CALC cycle 3
        start = 1'b1; dividend = 8'd35; divisor = 4'd5;
        @(negedge clk);                       // CALC cycle 4
        start = 1'b0;
        repeat (5) @(negedge clk);            // DONE cycle
        chk("ign_done", {31'd0, done}, 32'd1);
        chk("ign_quotient", {24'd0, quotient}, 32'd14);
        chk("ign_remainder", {28'd0, remainder}, 32'd2);
        start = 1'b1; dividend = 8'd35; divisor = 4'd5;
        @(negedge clk);
        start = 1'b0;
        chk("ign_busy_after", {31'd0, busy}, 32'd0);
        n = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done === 1'b1) n++;
        end
        chk("ign_no_second_done", n, 0);
        chk("ign_hold_quotient", {24'd0, quotient}, 32'd14);
        chk("ign_hold_remainder", {28'd0, remainder}, 32'd2);
        exp_quo = 8'd14; exp_rem = 4'd2; exp_dbz = 1'b0;

        // Reset mid-operation abandons the division
        @(negedge clk);
        start = 1'b1; dividend = 8'd255; divisor = 4'd1;
        @(negedge clk);                       // CALC cycle 1
        start = 1'b0;
        repeat (3) @(negedge clk);            // CALC cycle 4
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_busy", {31'd0, busy}, 32'd0);
        chk("mrst_quotient", {24'd0, quotient}, 32'd0);
        chk("mrst_remainder", {28'd0, remainder}, 32'd0);
        chk("mrst_done", {31'd0, done}, 32'd0);
        n = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done === 1'b1) n++;
        end
        chk("mrst_no_done", n, 0);
        exp_quo = '0; exp_rem = '0; exp_dbz = 1'b0;
        run_div(8'd8, 4'd9);

        // Randomised operands against the arithmetic reference
        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom);
            rb = 4'($urandom_range(15, 0));
            run_div(ra, rb);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_seq_restoring_divider
`default_nettype wire
